// File: rtl/traffic_light_controller_param_if.sv
// Lamp/request bundle between the intersection controller and its environment.
// master = request side (sensors, buttons, mode switch), slave = controller.
interface traffic_light_controller_param_if #(
    parameter int CNT_W = 4
);
    logic             side_req;
    logic             ped_req;
    logic             flash_en;
    logic [2:0]       light_M1;
    logic [2:0]       light_M2;
    logic [2:0]       light_MT;
    logic [2:0]       light_S;
    logic             walk;
    logic [3:0]       phase;
    logic [CNT_W-1:0] count;

    modport master (
        output side_req, ped_req, flash_en,
        input  light_M1, light_M2, light_MT, light_S, walk, phase, count
    );

    modport slave (
        input  side_req, ped_req, flash_en,
        output light_M1, light_M2, light_MT, light_S, walk, phase, count
    );
endinterface

// File: rtl/traffic_light_controller_param.sv
// Parametrised four-signal intersection controller with demand-actuated side
// phase, pedestrian walk and night flash mode. Lamps are decoded purely from
// the state/blink registers, so no input ever reaches an output combinationally.
module traffic_light_controller_param #(
    parameter int CNT_W   = 4,
    parameter int T_MAIN  = 7,
    parameter int T_TURN  = 5,
    parameter int T_SIDE  = 4,
    parameter int T_YEL   = 2,
    parameter int T_AR    = 1,
    parameter int T_FLASH = 4
) (
    input logic clk,
    input logic rst,
    traffic_light_controller_param_if.slave bus
);
    typedef enum logic [3:0] {
        S_MAIN  = 4'd0,
        S_M2Y   = 4'd1,
        S_TURN  = 4'd2,
        S_TY    = 4'd3,
        S_AR1   = 4'd4,
        S_SIDE  = 4'd5,
        S_SY    = 4'd6,
        S_AR2   = 4'd7,
        S_FLASH = 4'd8
    } state_t;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LD = 3'b000;

    // Timer reload values: a state of duration T starts at T-1 and leaves at 0.
    localparam logic [CNT_W-1:0] C_MAIN  = CNT_W'(T_MAIN - 1);
    localparam logic [CNT_W-1:0] C_TURN  = CNT_W'(T_TURN - 1);
    localparam logic [CNT_W-1:0] C_SIDE  = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] C_YEL   = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] C_AR    = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] C_FLASH = CNT_W'(T_FLASH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             blink_q, blink_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             take_side;

    logic [2:0] m1, m2, mt, s;
    logic       walk;

    function automatic logic [CNT_W-1:0] reload(state_t st);
        case (st)
            S_MAIN:       return C_MAIN;
            S_TURN:       return C_TURN;
            S_SIDE:       return C_SIDE;
            S_M2Y, S_TY,
            S_SY:         return C_YEL;
            S_AR1, S_AR2: return C_AR;
            S_FLASH:      return C_FLASH;
            default:      return C_MAIN;
        endcase
    endfunction

    // Next state, timer and blink; phases change only when the timer expires.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q - CNT_W'(1);
        blink_d   = blink_q;
        take_side = 1'b0;
        if (count_q == '0) begin
            if (state_q == S_FLASH) begin
                // Leave flash only after a complete on/off period.
                if (!blink_q && !bus.flash_en) begin
                    state_d = S_AR1;
                    count_d = C_AR;
                    blink_d = 1'b0;
                end else begin
                    count_d = C_FLASH;
                    blink_d = ~blink_q;
                end
            end else if (bus.flash_en) begin
                state_d = S_FLASH;
                count_d = C_FLASH;
                blink_d = 1'b1;
            end else begin
                case (state_q)
                    S_MAIN:  state_d = S_M2Y;
                    S_M2Y:   state_d = S_TURN;
                    S_TURN:  state_d = S_TY;
                    S_TY:    state_d = S_AR1;
                    S_AR1: begin
                        if (side_pend_q || ped_pend_q) begin
                            state_d   = S_SIDE;
                            take_side = 1'b1;
                        end else begin
                            state_d = S_MAIN;
                        end
                    end
                    S_SIDE:  state_d = S_SY;
                    S_SY:    state_d = S_AR2;
                    S_AR2:   state_d = S_MAIN;
                    default: state_d = S_MAIN;
                endcase
                count_d = reload(state_d);
            end
        end
    end

    // Request latches: a request on the servicing cycle outlives the clear.
    always_comb begin
        side_pend_d = bus.side_req | (side_pend_q & ~take_side);
        ped_pend_d  = bus.ped_req  | (ped_pend_q  & ~take_side);
    end

    // State, timer, blink and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_MAIN;
            count_q     <= C_MAIN;
            blink_q     <= 1'b0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            blink_q     <= blink_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
        end
    end

    // Lamp decode from state and blink only; unknown codes show all red.
    always_comb begin
        m1   = LR;
        m2   = LR;
        mt   = LR;
        s    = LR;
        walk = 1'b0;
        case (state_q)
            S_MAIN:  begin m1 = LG; m2 = LG; end
            S_M2Y:   begin m1 = LG; m2 = LY; end
            S_TURN:  begin m1 = LG; mt = LG; end
            S_TY:    begin m1 = LY; mt = LY; end
            S_SIDE:  begin s = LG; walk = 1'b1; end
            S_SY:    s = LY;
            S_FLASH: begin
                if (blink_q) begin
                    m1 = LY; m2 = LY; mt = LY; s = LR;
                end else begin
                    m1 = LD; m2 = LD; mt = LD; s = LD;
                end
            end
            default: ;
        endcase
    end

    assign bus.light_M1 = m1;
    assign bus.light_M2 = m2;
    assign bus.light_MT = mt;
    assign bus.light_S  = s;
    assign bus.walk     = walk;
    assign bus.phase    = state_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Bench for traffic_light_controller_param: a table of per-cycle vectors for
// the normal/actuated rounds, then hand sequences for flash and async reset.
module tb_traffic_light_controller_param;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    localparam logic [11:0] L_MAIN = {G, G, R, R};
    localparam logic [11:0] L_M2Y  = {G, Y, R, R};
    localparam logic [11:0] L_TURN = {G, R, G, R};
    localparam logic [11:0] L_TY   = {Y, R, Y, R};
    localparam logic [11:0] L_ALLR = {R, R, R, R};
    localparam logic [11:0] L_SIDE = {R, R, R, G};
    localparam logic [11:0] L_SY   = {R, R, R, Y};
    localparam logic [11:0] L_FON  = {Y, Y, Y, R};
    localparam logic [11:0] L_FOFF = {D, D, D, D};

    logic clk = 1'b0;
    logic rst = 1'b0;

    traffic_light_controller_param_if #(.CNT_W(4)) bus ();

    traffic_light_controller_param #(
        .CNT_W(4), .T_MAIN(7), .T_TURN(5), .T_SIDE(4),
        .T_YEL(2), .T_AR(1), .T_FLASH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        side;
        logic        ped;
        logic        flash;
        logic [3:0]  ph;
        logic [3:0]  cnt;
        logic [11:0] lamps;
        logic        walk;
    } vec_t;

    vec_t vecs[$];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [3:0] ph, input logic [3:0] cnt,
                       input logic [11:0] lamps, input logic walk);
        logic [20:0] act, exp;
        act = {bus.phase, bus.count, bus.light_M1, bus.light_M2, bus.light_MT,
               bus.light_S, bus.walk};
        exp = {ph, cnt, lamps, walk};
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: phase/count/lamps/walk got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                     name, act[20:17], act[16:13], act[12:1], act[0],
                     ph, cnt, lamps, walk);
        end
    endtask

    // Advance one cycle and check that S never shows G/Y alongside a main G/Y.
    task automatic tick();
        logic [2:0] mains;
        @(negedge clk);
        mains = (bus.light_M1 | bus.light_M2 | bus.light_MT) & 3'b011;
        nchk++;
        if (((bus.light_S & 3'b011) != 3'b000) && (mains != 3'b000)) begin
            nfail++;
            $display("FAIL invariant: S=%b with M1=%b M2=%b MT=%b at %0t",
                     bus.light_S, bus.light_M1, bus.light_M2, bus.light_MT, $time);
        end
    endtask

    task automatic add_seg(input logic [3:0] ph, input int dur, input logic [11:0] lamps,
                           input logic walk);
        vec_t v;
        for (int i = 0; i < dur; i++) begin
            v.side  = 1'b0;
            v.ped   = 1'b0;
            v.flash = 1'b0;
            v.ph    = ph;
            v.cnt   = 4'(dur - 1 - i);
            v.lamps = lamps;
            v.walk  = walk;
            vecs.push_back(v);
        end
    endtask

    // Round offsets: MAIN 0-6, M2Y 7-8, TURN 9-13, TY 14-15, AR1 16, SIDE 17-20, SY 21-22, AR2 23.
    task automatic add_round(input bit with_side, input int ped_at, input int side_a,
                             input int side_b);
        int base;
        base = vecs.size();
        add_seg(4'd0, 7, L_MAIN, 1'b0);
        add_seg(4'd1, 2, L_M2Y,  1'b0);
        add_seg(4'd2, 5, L_TURN, 1'b0);
        add_seg(4'd3, 2, L_TY,   1'b0);
        add_seg(4'd4, 1, L_ALLR, 1'b0);
        if (with_side) begin
            add_seg(4'd5, 4, L_SIDE, 1'b1);
            add_seg(4'd6, 2, L_SY,   1'b0);
            add_seg(4'd7, 1, L_ALLR, 1'b0);
        end
        if (ped_at >= 0) vecs[base + ped_at].ped = 1'b1;
        if (side_a >= 0) vecs[base + side_a].side = 1'b1;
        if (side_b >= 0) vecs[base + side_b].side = 1'b1;
    endtask

    task automatic run_seg(input string name, input logic [3:0] ph, input int dur,
                           input logic [11:0] lamps, input logic walk);
        for (int i = 0; i < dur; i++) begin
            chk(name, ph, 4'(dur - 1 - i), lamps, walk);
            tick();
        end
    endtask

    initial begin
        add_round(1'b0, -1, -1, -1);   // idle round, 17 cycles
        add_round(1'b1,  9, -1, -1);   // ped pulse on first TURN cycle, 24 cycles
        add_round(1'b0, -1, -1, -1);   // ped latch cleared: side skipped
        add_round(1'b1, -1,  2, 16);   // side pulse, then held on AR1->SIDE cycle
        add_round(1'b1, -1, -1, -1);   // side latch survived: serviced again
        add_round(1'b0, -1, -1, -1);   // now cleared

        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        bus.flash_en = 1'b0;
        rst          = 1'b0;

        @(negedge clk);                // t = 10ns
        chk("reset", 4'd0, 4'd6, L_MAIN, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("vec%0d", i), vecs[i].ph, vecs[i].cnt, vecs[i].lamps, vecs[i].walk);
            bus.side_req = vecs[i].side;
            bus.ped_req  = vecs[i].ped;
            bus.flash_en = vecs[i].flash;
            tick();
        end
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        bus.flash_en = 1'b0;

        // flash_en raised mid-MAIN: MAIN still runs all 7 cycles.
        for (int i = 0; i < 7; i++) begin
            chk("fl_main", 4'd0, 4'(6 - i), L_MAIN, 1'b0);
            if (i == 3) bus.flash_en = 1'b1;
            tick();
        end
        // First period; a ped pulse here must still be latched.
        for (int i = 0; i < 4; i++) begin
            chk("fl_on1", 4'd8, 4'(3 - i), L_FON, 1'b0);
            bus.ped_req = (i == 1);
            tick();
        end
        bus.ped_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fl_off1", 4'd8, 4'(3 - i), L_FOFF, 1'b0);
            tick();
        end
        // Drop flash_en mid blink-on: finish the off half before leaving.
        for (int i = 0; i < 4; i++) begin
            chk("fl_on2", 4'd8, 4'(3 - i), L_FON, 1'b0);
            if (i == 1) bus.flash_en = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("fl_off2", 4'd8, 4'(3 - i), L_FOFF, 1'b0);
            tick();
        end
        chk("fl_ar1", 4'd4, 4'd0, L_ALLR, 1'b0);
        tick();
        chk("fl_side0", 4'd5, 4'd3, L_SIDE, 1'b1);
        bus.side_req = 1'b1;           // latched, then lost to reset
        tick();
        bus.side_req = 1'b0;
        chk("fl_side1", 4'd5, 4'd2, L_SIDE, 1'b1);

        // Async reset between edges: outputs must fall back before the next edge.
        #2 rst = 1'b0;
        #1 chk("async_rst", 4'd0, 4'd6, L_MAIN, 1'b0);
        tick();
        rst = 1'b1;

        // Latches lost: plain round with no side phase.
        run_seg("pr_main", 4'd0, 7, L_MAIN, 1'b0);
        run_seg("pr_m2y",  4'd1, 2, L_M2Y,  1'b0);
        run_seg("pr_turn", 4'd2, 5, L_TURN, 1'b0);
        run_seg("pr_ty",   4'd3, 2, L_TY,   1'b0);
        run_seg("pr_ar1",  4'd4, 1, L_ALLR, 1'b0);
        chk("pr_no_side", 4'd0, 4'd6, L_MAIN, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
